psum_arbiter: RTL and testbench

Clocked round-robin controller that shares one `sum` adder unit (five 8-bit lanes reduced to one 8-bit result) between `NUM_REQ` partial-sum requesters in the convolution NOC. Requesters and the adder both use two-phase (transition) bundled-data handshakes. The arbiter synchronises these handshakes, grants one requester at a time, and drives the adder's request and acknowledge toggles. It returns each result with the requester id and guards against a stalled adder with a watchdog.

---
 rtl/noc_pkg.sv | 15 +
 rtl/sync2.sv | 23 ++
 rtl/psum_arbiter.sv | 141 ++++++++++++++
 tb/tb_psum_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and lane geometry for the convolution NOC partial-sum path.
package noc_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETURN,
        ERR
    } arb_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for toggle-style handshake signals, async active-low reset to 0.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/psum_arbiter.sv
// Round-robin arbiter sharing one two-phase lane-sum adder among NUM_REQ two-phase requesters.
module psum_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_IN  = NUM_LANES * LANE_W,
    parameter int WIDTH_OUT = LANE_W,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_tgl,
    input  logic [NUM_REQ*WIDTH_IN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           ack_tgl,
    output logic [WIDTH_OUT-1:0]         rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic                         sum_req,
    output logic [WIDTH_IN-1:0]          sum_data,
    input  logic                         sum_done,
    input  logic [WIDTH_OUT-1:0]         sum_result,
    output logic                         sum_ack,
    output logic                         busy,
    output logic                         err,
    output logic [15:0]                  txn_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    arb_state_t          state;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     gid;
    logic [WD_W-1:0]     wdog;
    logic [NUM_REQ-1:0]  req_sync;
    logic                sum_done_sync;
    logic [NUM_REQ-1:0]  pending;
    logic [ID_W:0]       grant;
    logic [ID_W-1:0]     grant_id;

    sync2 #(.W(NUM_REQ)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_tgl),
        .q     (req_sync)
    );

    sync2 #(.W(1)) u_done_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sum_done),
        .q     (sum_done_sync)
    );

    // Returns {found, id}: first pending requester after 'from', wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                              input logic [ID_W-1:0]    from);
        logic            found;
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(from) + k) % NUM_REQ);
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    assign pending  = req_sync ^ ack_tgl;
    assign grant    = rr_pick(pending, last);
    assign grant_id = grant[ID_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= ID_W'(NUM_REQ - 1);
            gid       <= '0;
            wdog      <= '0;
            ack_tgl   <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            sum_req   <= 1'b0;
            sum_data  <= '0;
            sum_ack   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[ID_W]) begin
                        sum_data <= req_data[int'(grant_id)*WIDTH_IN +: WIDTH_IN];
                        gid      <= grant_id;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                // sum_data settled last cycle; now raise the request edge
                ISSUE: begin
                    sum_req <= ~sum_req;
                    wdog    <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (sum_done_sync == sum_req) begin
                        rsp_data <= sum_result;
                        rsp_id   <= gid;
                        sum_ack  <= ~sum_ack;
                        state    <= RETURN;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        err          <= 1'b1;
                        rsp_data     <= '0;
                        rsp_id       <= gid;
                        ack_tgl[gid] <= ~ack_tgl[gid];
                        state        <= ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RETURN: begin
                    ack_tgl[gid] <= ~ack_tgl[gid];
                    last         <= gid;
                    txn_count    <= txn_count + 16'd1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                // Stalled adder: park here until reset, leaving its handshake untouched
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_arbiter.sv
// Bench for psum_arbiter: table-driven single requests, multi-requester order, watchdog and reset cases.
module tb_psum_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH_IN  = 40;
    localparam int WIDTH_OUT = 8;
    localparam int TIMEOUT   = 64;
    localparam int ADD_DLY   = 2;

    logic                        clk;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_tgl;
    logic [NUM_REQ*WIDTH_IN-1:0] req_data;
    logic [NUM_REQ-1:0]          ack_tgl;
    logic [WIDTH_OUT-1:0]        rsp_data;
    logic [1:0]                  rsp_id;
    logic                        sum_req;
    logic [WIDTH_IN-1:0]         sum_data;
    logic                        sum_done;
    logic [WIDTH_OUT-1:0]        sum_result;
    logic                        sum_ack;
    logic                        busy;
    logic                        err;
    logic [15:0]                 txn_count;

    psum_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_tgl    (req_tgl),
        .req_data   (req_data),
        .ack_tgl    (ack_tgl),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .sum_req    (sum_req),
        .sum_data   (sum_data),
        .sum_done   (sum_done),
        .sum_result (sum_result),
        .sum_ack    (sum_ack),
        .busy       (busy),
        .err        (err),
        .txn_count  (txn_count)
    );

    typedef struct {
        logic [1:0]  id;
        logic [39:0] data;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] res;
    } exp_t;

    vec_t   vecs[4];
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     ack_cnt[NUM_REQ];
    int     req_toggles = 0;
    logic   adder_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_sum(input logic [39:0] d);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 5; k++) s = s + d[k*8 +: 8];
        return s;
    endfunction

    // Adder model: answers each sum_req edge ADD_DLY cycles later unless disabled.
    initial begin
        logic req_seen;
        int   dly;
        req_seen = 1'b0;
        dly      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                req_seen = 1'b0;
                dly      = 0;
            end else if (sum_req != req_seen) begin
                req_seen = sum_req;
                req_toggles++;
                dly = ADD_DLY;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0 && adder_on) begin
                    sum_result = lane_sum(sum_data);
                    sum_done   = ~sum_done;
                end
            end
        end
    end

    // Scoreboard: every ack edge pops the oldest expectation.
    initial begin
        logic [NUM_REQ-1:0] prev_ack;
        exp_t e;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ack_tgl[i] != prev_ack[i]) begin
                        ack_cnt[i]++;
                        check("ack_has_expectation", 32'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("ack_requester", i, e.id);
                            check("rsp_id", rsp_id, e.id);
                            check("rsp_data", rsp_data, e.res);
                        end
                    end
                end
            end
            prev_ack = ack_tgl;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    task automatic do_req(input int id, input logic [39:0] data);
        check("protocol_not_pending", ack_tgl[id], req_tgl[id]);
        req_data[id*WIDTH_IN +: WIDTH_IN] = data;
        req_tgl[id] = ~req_tgl[id];
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_within_budget", 32'(n < budget), 1);
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        req_tgl  = '0;
        sum_done = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack_tgl"},   ack_tgl,   0);
        check({tag, "_rsp_data"},  rsp_data,  0);
        check({tag, "_rsp_id"},    rsp_id,    0);
        check({tag, "_sum_req"},   sum_req,   0);
        check({tag, "_sum_data"},  sum_data,  0);
        check({tag, "_sum_ack"},   sum_ack,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_txn_count"}, txn_count, 0);
    endtask

    initial begin
        logic        old_req;
        logic        new_req;
        logic        old_ack;
        logic [7:0]  b;
        int          n;

        vecs[0] = '{2'd1, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd15};
        vecs[1] = '{2'd3, {5{8'hFF}}, 8'hFB};
        vecs[2] = '{2'd0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50}, 8'd150};
        vecs[3] = '{2'd2, {8'd200, 8'd100, 8'd0, 8'd0, 8'd1}, 8'd45};

        reset      = 1'b1;
        req_tgl    = '0;
        req_data   = '0;
        sum_done   = 1'b0;
        sum_result = '0;
        adder_on   = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single requests from the table, with request-edge latency
        for (int v = 0; v < 4; v++) begin
            old_req = sum_req;
            new_req = !old_req;
            n = req_toggles;
            exp_q.push_back('{vecs[v].id, vecs[v].exp});
            do_req(int'(vecs[v].id), vecs[v].data);
            repeat (3) begin @(posedge clk); #1; end
            check("issue_not_before_edge4", sum_req, old_req);
            @(posedge clk); #1;
            check("issue_at_edge4", sum_req, new_req);
            wait_done(100);
            check("vec_rsp_data", rsp_data, vecs[v].exp);
            check("vec_rsp_id", rsp_id, vecs[v].id);
            check("vec_txn_count", txn_count, v + 1);
            check("vec_one_sum_req", req_toggles - n, 1);
            check("vec_sum_ack_phase", sum_ack, sum_done);
        end

        // All requesters pending at once from reset: order 0,1,2,3
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            b = 8'(i + 1);
            exp_q.push_back('{2'(i), 8'(5 * (i + 1))});
            do_req(i, {5{b}});
        end
        wait_done(400);
        for (int i = 0; i < NUM_REQ; i++) check("all4_one_ack_each", ack_cnt[i], 1);
        check("all4_txn_count", txn_count, 4);

        // Fairness: requester 0 re-requests at once while requester 2 waits
        apply_reset();
        exp_q.push_back('{2'd0, 8'd15});
        do_req(0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
        @(posedge clk); #1;
        exp_q.push_back('{2'd2, 8'd50});
        do_req(2, {5{8'd10}});
        n = 0;
        while (ack_tgl[0] != req_tgl[0] && n < 100) begin @(posedge clk); #1; n++; end
        check("fair_ack0_seen", 32'(n < 100), 1);
        exp_q.push_back('{2'd0, 8'd44});
        do_req(0, {8'd100, 8'd100, 8'd100, 8'd0, 8'd0});
        wait_done(200);
        check("fair_ack_cnt0", ack_cnt[0], 2);
        check("fair_ack_cnt2", ack_cnt[2], 1);
        check("fair_txn_count", txn_count, 3);

        // Watchdog: adder silent
        apply_reset();
        adder_on = 1'b0;
        exp_q.push_back('{2'd1, 8'd0});
        old_req = sum_req;
        new_req = !old_req;
        do_req(1, {5{8'h11}});
        n = 0;
        while (sum_req == old_req && n < 20) begin @(posedge clk); #1; n++; end
        check("wd_issued", sum_req, new_req);
        n = 0;
        while (!err && n < 200) begin @(posedge clk); #1; n++; end
        check("wd_cycles_in_wait", n, TIMEOUT);
        check("wd_err", err, 1);
        check("wd_rsp_data", rsp_data, 0);
        check("wd_rsp_id", rsp_id, 1);
        check("wd_busy", busy, 1);
        repeat (2) begin @(posedge clk); #1; end
        check("wd_ack_returned", ack_tgl[1], req_tgl[1]);
        check("wd_queue_drained", exp_q.size(), 0);
        old_req = sum_req;
        old_ack = sum_ack;
        do_req(3, {5{8'h22}});
        repeat (20) begin @(posedge clk); #1; end
        check("wd_no_new_grant", sum_req, old_req);
        check("wd_sum_ack_frozen", sum_ack, old_ack);
        check("wd_req3_unserved", ack_tgl[3], 0);
        check("wd_txn_count", txn_count, 0);
        check("wd_err_sticky", err, 1);

        // Async reset in the middle of WAIT, then normal service
        apply_reset();
        adder_on = 1'b1;
        exp_q.push_back('{2'd3, 8'd15});
        do_req(3, {5{8'd3}});
        wait_done(100);
        adder_on = 1'b0;
        do_req(1, {5{8'd7}});
        n = 0;
        old_req = sum_req;
        while (sum_req == old_req && n < 20) begin @(posedge clk); #1; n++; end
        repeat (5) begin @(posedge clk); #1; end
        check("midwait_busy_before", busy, 1);
        #2;
        reset    = 1'b0;
        req_tgl  = '0;
        sum_done = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midwait");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        adder_on = 1'b1;
        exp_q.push_back('{2'd1, 8'd35});
        do_req(1, {5{8'd7}});
        wait_done(100);
        check("post_reset_txn_count", txn_count, 1);
        check("post_reset_rsp_data", rsp_data, 35);
        check("post_reset_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
